// File: rtl/wave_gen_dds.sv
// Direct-digital-synthesis waveform generator: a sample-rate divider ticks a phase
// accumulator. Each tick pushes one sample through a three-stage pipeline:
// capture, raw waveform, then amplitude scaling into a valid/ready output register
// that flags dropped samples as overrun.
module wave_gen_dds #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned DIV_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic [1:0]         mode_i,
  input  logic [8:0]         amp_i,
  input  logic               phase_clr_i,
  input  logic               overrun_clr_i,
  output logic [DATA_W-1:0]  sample_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i,
  output logic               overrun_o
);

  localparam logic [DATA_W-1:0] Mid = {1'b1, {(DATA_W-1){1'b0}}};

  // Full-wave sine table, evaluated at elaboration time.
  function automatic logic [DATA_W-1:0] sine_entry(int unsigned k);
    real pi, mid, x;
    pi  = 3.14159265358979323846;
    mid = 2.0 ** (DATA_W - 1);
    x   = mid + (mid - 1.0) * $sin(2.0 * pi * real'(k) / (2.0 ** LUT_AW));
    return DATA_W'($rtoi($floor(x + 0.5)));
  endfunction

  logic [DATA_W-1:0] sine_rom [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic [DATA_W-1:0] RomVal = sine_entry(k);
    assign sine_rom[k] = RomVal;
  end

  // Divider / phase state.
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tick;
  logic [8:0]         amp_eff;

  // Stage 1: captured phase (only the top bits any waveform needs), mode and gain.
  logic              s1_valid_q;
  logic [DATA_W:0]   s1_top_q;
  logic [1:0]        s1_mode_q;
  logic [8:0]        s1_amp_q;

  // Stage 2: raw unsigned waveform value.
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_raw_q, raw;
  logic [8:0]        s2_amp_q;

  // Stage 3 (combinational) and output register.
  logic signed [DATA_W:0]    diff;
  logic signed [DATA_W+10:0] prod;
  logic [DATA_W-1:0]         scaled;
  logic [DATA_W-1:0]         sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      load, drop;

  assign tick    = en_i && (cnt_q == div_i);
  assign amp_eff = (amp_i > 9'd256) ? 9'd256 : amp_i;

  // Next divider count and phase; a clear beats a simultaneous tick increment.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || tick) begin
      cnt_d = '0;
    end
    phase_d = phase_q;
    if (phase_clr_i) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = phase_q + phase_inc_i;
    end
  end

  // Divider counter and phase accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Stage 1 captures the pre-update phase plus per-sample settings on a tick only,
  // so later setting changes cannot disturb a sample already in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_top_q   <= '0;
      s1_mode_q  <= '0;
      s1_amp_q   <= '0;
    end else begin
      s1_valid_q <= tick;
      if (tick) begin
        s1_top_q  <= phase_q[PHASE_W-1 -: DATA_W+1];
        s1_mode_q <= mode_i;
        s1_amp_q  <= amp_eff;
      end
    end
  end

  // Raw waveform selection from the captured phase.
  always_comb begin
    raw = '0;
    case (s1_mode_q)
      2'd0:    raw = sine_rom[s1_top_q[DATA_W -: LUT_AW]];
      2'd1:    raw = s1_top_q[DATA_W] ? ~s1_top_q[DATA_W-1:0] : s1_top_q[DATA_W-1:0];
      2'd2:    raw = s1_top_q[DATA_W:1];
      default: raw = {DATA_W{s1_top_q[DATA_W]}};
    endcase
  end

  // Stage 2 register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_raw_q   <= '0;
      s2_amp_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_raw_q <= raw;
        s2_amp_q <= s1_amp_q;
      end
    end
  end

  // Scale around mid-scale; the arithmetic shift floors, and at unity gain the
  // result spans exactly 0..2^DATA_W-1 so no clamp is required.
  always_comb begin
    diff   = $signed({1'b0, s2_raw_q}) - $signed({1'b0, Mid});
    prod   = diff * $signed({1'b0, s2_amp_q});
    scaled = Mid + DATA_W'(prod >>> 8);
  end

  // Output handshake: load when empty or being accepted, otherwise drop and flag.
  always_comb begin
    load      = s2_valid_q && (!valid_q || sample_ready_i);
    drop      = s2_valid_q && valid_q && !sample_ready_i;
    sample_d  = load ? scaled : sample_q;
    valid_d   = load || (valid_q && !sample_ready_i);
    overrun_d = drop || (overrun_q && !overrun_clr_i);
  end

  // Output register and sticky overrun flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q  <= Mid;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_wave_gen_dds.sv
// Self-checking bench for wave_gen_dds: directed scenarios plus a randomized run,
// all compared cycle by cycle against a behavioural model of the generator.
module tb_wave_gen_dds;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [23:0] inc;
  logic [1:0]  mode;
  logic [8:0]  amp;
  logic        clr;
  logic        oclr;
  logic        ready;
  logic [11:0] sample;
  logic        valid;
  logic        ovr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state.
  int unsigned m_phase;
  int          m_cnt;
  bit          dl_v [2];
  int          dl_s [2];
  bit          m_valid;
  int          m_sample;
  bit          m_ovr;

  logic [11:0] got_q [$];
  int          when_q [$];

  always #5 clk = ~clk;

  wave_gen_dds dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .div_i          (div),
    .phase_inc_i    (inc),
    .mode_i         (mode),
    .amp_i          (amp),
    .phase_clr_i    (clr),
    .overrun_clr_i  (oclr),
    .sample_o       (sample),
    .sample_valid_o (valid),
    .sample_ready_i (ready),
    .overrun_o      (ovr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Waveform value for a given phase/mode/gain, straight from the waveform formulas.
  function automatic int gen(int unsigned ph, int md, int a);
    int  raw, ae, d, p;
    real x;
    raw = 0;
    case (md)
      0: begin
        x   = 2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * real'(ph >> 16) / 256.0);
        raw = $rtoi($floor(x + 0.5));
      end
      1: begin
        p   = int'(ph >> 11);
        raw = (p >= 4096) ? 8191 - p : p;
      end
      2: raw = int'(ph >> 12);
      default: raw = (ph >= 32'h80_0000) ? 4095 : 0;
    endcase
    ae = (a > 256) ? 256 : a;
    d  = raw - 2048;
    return 2048 + $rtoi($floor(real'(d * ae) / 256.0));
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_cnt    = 0;
    dl_v[0]  = 0;
    dl_v[1]  = 0;
    m_valid  = 0;
    m_sample = 2048;
    m_ovr    = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit tk, arr_v, set;
    int arr_s;
    tk = en && (m_cnt == int'(div));
    if (!en || tk) m_cnt = 0;
    else m_cnt++;
    arr_v   = dl_v[1];
    arr_s   = dl_s[1];
    dl_v[1] = dl_v[0];
    dl_s[1] = dl_s[0];
    dl_v[0] = tk;
    if (tk) dl_s[0] = gen(m_phase, int'(mode), int'(amp));
    if (clr) m_phase = 0;
    else if (tk) m_phase = (m_phase + int'(inc)) & 32'hFF_FFFF;
    set = arr_v && m_valid && !ready;
    if (arr_v && (!m_valid || ready)) begin
      m_valid  = 1;
      m_sample = arr_s;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    if (set) m_ovr = 1;
    else if (oclr) m_ovr = 0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("sample", {20'd0, sample}, m_sample);
    chk("overrun", {31'd0, ovr}, {31'd0, m_ovr});
  endtask

  // Stop ticking, clear phase and let the pipeline and output drain.
  task automatic quiesce();
    en    = 0;
    clr   = 1;
    ready = 1;
    oclr  = 0;
    cycle();
    clr = 0;
    repeat (4) cycle();
  endtask

  // Gather n accepted samples (ready held by caller), bounded in cycles.
  task automatic collect(input int n);
    int budget;
    budget = n * 20 + 40;
    got_q.delete();
    when_q.delete();
    while (got_q.size() < n && budget > 0) begin
      cycle();
      budget--;
      if (valid && ready) begin
        got_q.push_back(sample);
        when_q.push_back(cyc);
      end
    end
    chk("collect_count", got_q.size(), n);
  endtask

  initial begin
    int          nvalid;
    int          expn;
    logic [11:0] e;

    rst_n = 1; en = 0; div = 0; inc = 0; mode = 0; amp = 0;
    clr = 0; oclr = 0; ready = 0;
    model_reset();
    #2 rst_n = 0;
    #1;
    chk("reset_sample", {20'd0, sample}, 32'h800);
    chk("reset_valid", {31'd0, valid}, 0);
    chk("reset_overrun", {31'd0, ovr}, 0);
    @(negedge clk) rst_n = 1;

    // Sawtooth at one sample per clock.
    quiesce();
    div = 0; inc = 24'h10_0000; amp = 256; mode = 2; ready = 1; en = 1;
    cycle(); chk("saw_lat1", {31'd0, valid}, 0);
    cycle(); chk("saw_lat2", {31'd0, valid}, 0);
    cycle(); chk("saw_lat3", {31'd0, valid}, 1);
    chk("saw_first", {20'd0, sample}, 0);
    collect(16);
    for (int i = 0; i < 16; i++) begin
      e = 12'((i + 1) * 256);
      chk("saw_seq", {20'd0, got_q[i]}, {20'd0, e});
    end

    // Square at half gain, then over-unity gain.
    quiesce();
    mode = 3; inc = 24'h40_0000; amp = 128; en = 1;
    collect(8);
    for (int i = 0; i < 8; i++) begin
      e = (i % 4 < 2) ? 12'h400 : 12'hBFF;
      chk("sq_half", {20'd0, got_q[i]}, {20'd0, e});
    end
    quiesce();
    amp = 300; en = 1;
    collect(4);
    for (int i = 0; i < 4; i++) begin
      e = (i < 2) ? 12'h000 : 12'hFFF;
      chk("sq_full", {20'd0, got_q[i]}, {20'd0, e});
    end

    // Sine quadrant points.
    quiesce();
    mode = 0; inc = 24'h04_0000; amp = 256; en = 1;
    collect(64);
    chk("sine_0", {20'd0, got_q[0]}, 32'h800);
    chk("sine_64", {20'd0, got_q[16]}, 32'hFFF);
    chk("sine_128", {20'd0, got_q[32]}, 32'h800);
    chk("sine_192", {20'd0, got_q[48]}, 32'h001);

    // Backpressure and overrun.
    quiesce();
    mode = 2; inc = 24'h10_0000; amp = 256; div = 3; ready = 0; en = 1;
    for (int i = 0; i < 20 && !valid; i++) cycle();
    chk("bp_first_valid", {31'd0, valid}, 1);
    chk("bp_first_sample", {20'd0, sample}, 0);
    repeat (3) cycle();
    chk("bp_no_ovr_yet", {31'd0, ovr}, 0);
    cycle();
    chk("bp_ovr_set", {31'd0, ovr}, 1);
    chk("bp_held", {20'd0, sample}, 0);
    oclr = 1;
    cycle();
    oclr = 0;
    chk("bp_ovr_clr", {31'd0, ovr}, 0);
    ready = 1;
    collect(3);
    ready = 0;
    for (int i = 0; i < 20 && !(valid && dl_v[1]); i++) cycle();
    chk("bp_arrival_pending", {31'd0, valid && dl_v[1]}, 1);
    expn  = (m_sample + 256) % 4096;
    ready = 1;
    cycle();
    chk("bp_same_cycle_ovr", {31'd0, ovr}, 0);
    chk("bp_same_cycle_valid", {31'd0, valid}, 1);
    chk("bp_same_cycle_sample", {20'd0, sample}, expn);

    // Divider spacing and phase clear on a triangle.
    quiesce();
    div = 9; mode = 1; amp = 256; inc = 24'h08_0000; ready = 1; en = 1;
    collect(4);
    for (int i = 0; i < 3; i++) chk("div_interval", when_q[i+1] - when_q[i], 10);
    clr = 1;
    cycle();
    clr = 0;
    collect(2);
    chk("clr_first", {20'd0, got_q[0]}, 32'h000);
    chk("clr_second", {20'd0, got_q[1]}, 32'h100);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        en  = 0;
        div = 16'($urandom_range(0, 3));
      end else begin
        en = ($urandom_range(0, 7) != 0);
      end
      mode  = 2'($urandom_range(0, 3));
      amp   = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) inc = 24'($urandom);
      clr   = ($urandom_range(0, 15) == 0);
      oclr  = ($urandom_range(0, 7) == 0);
      ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Asynchronous reset with a sample pending, then idle with en low.
    quiesce();
    div = 0; mode = 2; amp = 256; ready = 0; en = 1;
    for (int i = 0; i < 20 && !valid; i++) cycle();
    chk("rst_pre_valid", {31'd0, valid}, 1);
    #3 rst_n = 0;
    #1;
    chk("rst_mid_sample", {20'd0, sample}, 32'h800);
    chk("rst_mid_valid", {31'd0, valid}, 0);
    chk("rst_mid_overrun", {31'd0, ovr}, 0);
    model_reset();
    en = 0; clr = 0; oclr = 0;
    @(negedge clk) rst_n = 1;
    nvalid = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (valid) nvalid++;
    end
    chk("idle_valid_count", nvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_gen_dds.md
# wave_gen_dds

Parametrised direct-digital-synthesis waveform generator and the successor to the fixed-table 500 Hz signal source. A programmable sample-rate divider drives a phase accumulator. Each sample can be a sine (elaborated ROM), triangle, sawtooth or square, and is amplitude-scaled around mid-scale. Samples go to the DAC/serialiser stage over a valid/ready handshake, with overrun detection.

## Interface
Parameters:
- DATA_W, 12: sample width; mid-scale MID = 2^(DATA_W-1).
- PHASE_W, 24: phase accumulator width.
- LUT_AW, 8: sine ROM address width (2^LUT_AW entries, full wave).
- DIV_W, 16: sample-rate divider width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enables sample ticks.
- div  in  DIV_W  one tick every div+1 clocks.
- phase_inc  in  PHASE_W  phase step per tick.
- mode  in  2  waveform select: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- amp  in  9  gain in 1/256 units; values above 256 are treated as 256 (unity).
- phase_clr  in  1  synchronous clear of the phase accumulator.
- overrun_clr  in  1  clears the overrun flag.
- sample  out  DATA_W  output sample.
- sample_valid  out  1  sample is valid.
- sample_ready  in  1  downstream accepts the sample.
- overrun  out  1  sticky: a sample was dropped.

## Operation
- Divider: while en=1, the counter runs 0..div. A tick fires in the cycle the counter equals div, then the counter returns to 0. With div=0 a tick fires every clock. With en=0 the counter is held at 0 and no ticks fire; a pending output still completes its handshake.
- Phase: on a tick, stage 1 captures the current phase, mode and amp_eff. The accumulator then becomes phase + phase_inc, modulo 2^PHASE_W.
  - phase_clr=1 forces phase to 0 at the next edge; it has priority over a simultaneous tick increment.
  - A tick in the same cycle as phase_clr still samples the pre-clear phase.
- Raw generation (stage 2), all unsigned DATA_W:
  - sine: ROM[phase top LUT_AW bits]. ROM[k] = round(MID + (MID-1)·sin(2πk/2^LUT_AW)), computed at elaboration.
  - triangle: p = top DATA_W+1 phase bits; raw = p[DATA_W] ? ~p[DATA_W-1:0] : p[DATA_W-1:0].
  - sawtooth: top DATA_W phase bits.
  - square: phase MSB ? 2^DATA_W-1 : 0.
- Scaling (stage 3):
  - d = raw − MID, signed DATA_W+1 bits.
  - out = MID + ((d·amp_eff) >>> 8), arithmetic shift (floor).
  - No clamp is needed: full range is preserved at amp 256, and amp 0 gives MID.
- Output register:
  - A stage-3 result loads into sample and sets sample_valid if the register is empty, or if sample_ready=1 in that same cycle. Simultaneous accept-and-load produces no bubble and no overrun.
  - If sample_valid=1 and sample_ready=0 when a result arrives, the result is dropped, sample is held and overrun is set. The phase keeps advancing.
  - A handshake completes on sample_valid & sample_ready; sample_valid then drops unless a new result loads.
  - overrun_clr clears overrun; a set event in the same cycle wins.
- mode, amp and phase_inc may change at any time. They take effect only from the next tick, so no intra-sample glitch occurs.

## Timing
- Reset (any time, including mid-pipeline): sample=MID, sample_valid=0, overrun=0, phase=0, divider=0, pipeline valids=0. Outputs change asynchronously on assertion of rst_n.
- Latency: tick in cycle T, sample/sample_valid visible in cycle T+3.
- Throughput: one sample per clock at div=0 with sample_ready held high.
- sample is stable while sample_valid=1 and sample_ready=0.

## Test plan
- Reset: assert rst_n mid-run with valid pending. Required: sample=0x800, sample_valid=0, overrun=0 immediately. After release with en=0, sample_valid stays 0 for 100 clocks.
- Sawtooth: div=0, phase_inc=0x100000, amp=256, ready=1, mode=2. Required: samples 0x000, 0x100, …, 0xF00, 0x000, first valid 3 clocks after the first tick.
- Square at half gain: mode=3, phase_inc=0x400000, amp=128. Required: sequence 0x400, 0x400, 0xBFF, 0xBFF, repeating. amp=300 gives 0x000, 0x000, 0xFFF, 0xFFF.
- Sine: mode=0, phase_inc=0x040000. Required: samples at indices 0/64/128/192 are 0x800/0xFFF/0x800/0x001.
- Backpressure: div=3, ready=0. Required: first sample held, overrun=1 four clocks later, sample unchanged. overrun_clr clears it. Ready=1 then drains normally. Ready rising in the same cycle as a new load gives no overrun.
- Divider/phase_clr: div=9, mode=1, amp=256. Required: valid every 10 clocks. phase_clr pulsed gives the following sample 0x000, then triangle resumes from 0.
